// File: rtl/gamepad_pkg.sv
// Shared types and constants for the gamepad poll controller.
// Holds state encoding, pre-reversed command bytes, ID/ACK constants,
// frame length and the byte bit-reverse helper.
package gamepad_pkg;

  localparam int unsigned CNT_W     = 20;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned FRAME_LEN = 5;

  localparam logic [BYTE_W-1:0] ID_DIGITAL = 8'h41;
  localparam logic [BYTE_W-1:0] ID_ANALOG  = 8'h73;
  localparam logic [BYTE_W-1:0] ACK_BYTE   = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SEND,
    ST_WAIT_RX,
    ST_GAP,
    ST_CS_HOLD
  } state_e;

  // Gamepad is LSB-first while the SPI master shifts MSB-first.
  function automatic logic [BYTE_W-1:0] bit_rev8(input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Command frame 0x01,0x42,0x00,0x00,0x00 stored already bit-reversed.
  function automatic logic [BYTE_W-1:0] cmd_byte_rev(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    return 8'h80;
      3'd1:    return 8'h42;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/gamepad_poll_ctrl_if.sv
// Byte-level handshake between the poll controller and the SPI master,
// plus the gamepad chip select.
//   o_TX_BYTE/o_TX_DV : byte to send and its one-cycle strobe
//   i_TX_READY        : SPI master idle
//   i_RX_DV/i_RX_DATA : received byte strobe and data
//   o_CS_N            : gamepad select (ATT), active-low
interface gamepad_poll_ctrl_if;
  import gamepad_pkg::*;

  logic [BYTE_W-1:0] o_TX_BYTE;
  logic              o_TX_DV;
  logic              i_TX_READY;
  logic              i_RX_DV;
  logic [BYTE_W-1:0] i_RX_DATA;
  logic              o_CS_N;

  modport master (
    output o_TX_BYTE, o_TX_DV, o_CS_N,
    input  i_TX_READY, i_RX_DV, i_RX_DATA
  );

  modport slave (
    input  o_TX_BYTE, o_TX_DV, o_CS_N,
    output i_TX_READY, i_RX_DV, i_RX_DATA
  );

endinterface

// File: rtl/clk_delay_cnt.sv
// Loadable 20-bit down-counter, saturating at zero.
//   load_i/load_val_i : load a new count (takes priority over counting)
//   done_o            : registered flag, high while the count is zero
module clk_delay_cnt
  import gamepad_pkg::*;
(
  input  logic             i_CLK,
  input  logic             i_RESET_N,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q;

  // Next count: load, else decrement toward zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = load_val_i;
    else if (cnt_q != '0)    cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      cnt_q  <= '0;
      done_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= (cnt_d == '0);
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/gamepad_poll_ctrl.sv
// Periodic PlayStation-style gamepad poller driving an SPI byte master.
//   i_CLK, i_RESET_N : clock, async active-low reset
//   i_ENABLE         : polling enable
//   bus              : SPI byte handshake and chip select (master modport)
//   o_BUTTONS        : latest button word, 1 = pressed
//   o_BUTTONS_VALID  : pulse when o_BUTTONS updated
//   o_ERR            : pulse on timeout or bad ID/ACK
//   o_BUSY           : high while chip select is asserted
module gamepad_poll_ctrl
  import gamepad_pkg::*;
#(
  parameter int unsigned c_POLL_CLKS     = 500000,
  parameter int unsigned c_CS_SETUP_CLKS = 50,
  parameter int unsigned c_BYTE_GAP_CLKS = 100,
  parameter int unsigned c_TIMEOUT_CLKS  = 1000
) (
  input  logic                 i_CLK,
  input  logic                 i_RESET_N,
  input  logic                 i_ENABLE,
  gamepad_poll_ctrl_if.master  bus,
  output logic [15:0]          o_BUTTONS,
  output logic                 o_BUTTONS_VALID,
  output logic                 o_ERR,
  output logic                 o_BUSY
);

  // Loads are one less than the phase length: the action fires in the
  // cycle the count reads zero and its registered effect lands one later.
  localparam logic [CNT_W-1:0] SETUP_LOAD   = CNT_W'(c_CS_SETUP_CLKS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(c_BYTE_GAP_CLKS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(c_TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0] POLL_LOAD    = CNT_W'(c_POLL_CLKS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(FRAME_LEN - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
  logic              tx_dv_q, tx_dv_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic [15:0]       buttons_q, buttons_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              id_ok_q, id_ok_d;
  logic              ack_ok_q, ack_ok_d;
  logic [BYTE_W-1:0] btn_lo_q, btn_lo_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_done;
  logic              send_now;
  logic              finish;
  logic              frame_ok;
  logic [BYTE_W-1:0] rx_log;

  // Single counter shared by poll, setup, gap and timeout phases.
  clk_delay_cnt u_cnt (
    .i_CLK      (i_CLK),
    .i_RESET_N  (i_RESET_N),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .done_o     (cnt_done)
  );

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tx_byte_d = tx_byte_q;
    tx_dv_d   = 1'b0;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    buttons_d = buttons_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    id_ok_d   = id_ok_q;
    ack_ok_d  = ack_ok_q;
    btn_lo_d  = btn_lo_q;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    send_now  = 1'b0;
    finish    = 1'b0;
    frame_ok  = 1'b0;
    rx_log    = bit_rev8(bus.i_RX_DATA);

    case (state_q)
      // CS_HOLD lasts one cycle but may start the next poll itself.
      ST_IDLE, ST_CS_HOLD: begin
        state_d = ST_IDLE;
        if (cnt_done && i_ENABLE) begin
          state_d  = ST_CS_SETUP;
          cs_n_d   = 1'b0;
          busy_d   = 1'b1;
          idx_d    = '0;
          id_ok_d  = 1'b0;
          ack_ok_d = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = SETUP_LOAD;
        end
      end
      ST_CS_SETUP, ST_GAP: begin
        if (cnt_done) begin
          state_d  = ST_SEND;
          send_now = bus.i_TX_READY;
        end
      end
      ST_SEND: send_now = bus.i_TX_READY;
      ST_WAIT_RX: begin
        if (bus.i_RX_DV) begin
          case (idx_q)
            3'd1:    id_ok_d  = (rx_log == ID_DIGITAL) || (rx_log == ID_ANALOG);
            3'd2:    ack_ok_d = (rx_log == ACK_BYTE);
            3'd3:    btn_lo_d = rx_log;
            default: ;
          endcase
          if (idx_q == LAST_IDX) begin
            finish   = 1'b1;
            frame_ok = id_ok_q && ack_ok_q;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            state_d  = ST_GAP;
            cnt_load = 1'b1;
            cnt_val  = GAP_LOAD;
          end
        end else if (cnt_done) begin
          finish = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Byte launch: from SEND, or straight out of a finished setup/gap.
    if (send_now) begin
      tx_dv_d   = 1'b1;
      tx_byte_d = cmd_byte_rev(idx_q);
      state_d   = ST_WAIT_RX;
      cnt_load  = 1'b1;
      cnt_val   = TIMEOUT_LOAD;
    end

    // Frame end (last byte or timeout): release CS and publish the result.
    if (finish) begin
      state_d  = ST_CS_HOLD;
      cs_n_d   = 1'b1;
      busy_d   = 1'b0;
      cnt_load = 1'b1;
      cnt_val  = POLL_LOAD;
      if (frame_ok) begin
        buttons_d = ~{rx_log, btn_lo_q};
        valid_d   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      tx_byte_q <= '0;
      tx_dv_q   <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      buttons_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      id_ok_q   <= 1'b0;
      ack_ok_q  <= 1'b0;
      btn_lo_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tx_byte_q <= tx_byte_d;
      tx_dv_q   <= tx_dv_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      buttons_q <= buttons_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      id_ok_q   <= id_ok_d;
      ack_ok_q  <= ack_ok_d;
      btn_lo_q  <= btn_lo_d;
    end
  end

  assign bus.o_TX_BYTE    = tx_byte_q;
  assign bus.o_TX_DV      = tx_dv_q;
  assign bus.o_CS_N       = cs_n_q;
  assign o_BUTTONS        = buttons_q;
  assign o_BUTTONS_VALID  = valid_q;
  assign o_ERR            = err_q;
  assign o_BUSY           = busy_q;

endmodule

// File: tb/tb_gamepad_poll_ctrl.sv
// Self-checking bench for gamepad_poll_ctrl: a gamepad responder driven from
// a table of frames, with a scoreboard of expected outcomes checked by a
// monitor, plus hand-written stall, timeout, reset and enable sequences.
module tb_gamepad_poll_ctrl;

  localparam int unsigned P_POLL  = 40;
  localparam int unsigned P_SETUP = 5;
  localparam int unsigned P_GAP   = 4;
  localparam int unsigned P_TMO   = 20;
  localparam int RESP_DLY = 3;
  localparam int BUDGET   = 400;
  localparam int STALL    = 60;
  localparam int NVEC     = 10;

  localparam logic [2:0] M_NORM   = 3'd0;
  localparam logic [2:0] M_DROP   = 3'd1;
  localparam logic [2:0] M_STALL  = 3'd2;
  localparam logic [2:0] M_RESET  = 3'd3;
  localparam logic [2:0] M_ENDROP = 3'd4;

  typedef struct packed {
    logic [7:0]  id;
    logic [7:0]  ack;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [2:0]  mode;
    logic        exp_err;
    logic [15:0] exp_btn;
  } frame_vec_t;

  typedef struct packed {
    logic        is_err;
    logic [15:0] btn;
    logic [31:0] when;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] buttons;
  logic        bvalid;
  logic        err;
  logic        busy;

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         exp_fall = -1;
  sb_t        sb_q[$];
  sb_t        mon_e;
  frame_vec_t vecs[NVEC];
  logic [7:0] cmd_exp[5];

  gamepad_poll_ctrl_if spi();

  gamepad_poll_ctrl #(
    .c_POLL_CLKS     (P_POLL),
    .c_CS_SETUP_CLKS (P_SETUP),
    .c_BYTE_GAP_CLKS (P_GAP),
    .c_TIMEOUT_CLKS  (P_TMO)
  ) dut (
    .i_CLK           (clk),
    .i_RESET_N       (rst_n),
    .i_ENABLE        (enable),
    .bus             (spi),
    .o_BUTTONS       (buttons),
    .o_BUTTONS_VALID (bvalid),
    .o_ERR           (err),
    .o_BUSY          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_line(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=no-event required=event-within-%0d-cycles", name, BUDGET);
  endtask

  task automatic wait_tx(output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (spi.o_TX_DV) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_cs_fall(output bit ok, output int at);
    logic prev;
    ok = 1'b0;
    at = 0;
    prev = spi.o_CS_N;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (prev && !spi.o_CS_N) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
      prev = spi.o_CS_N;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"},    32'(spi.o_CS_N),    32'd1);
    check({tag, "_tx_byte"}, 32'(spi.o_TX_BYTE), 32'd0);
    check({tag, "_tx_dv"},   32'(spi.o_TX_DV),   32'd0);
    check({tag, "_buttons"}, 32'(buttons),       32'd0);
    check({tag, "_valid"},   32'(bvalid),        32'd0);
    check({tag, "_err"},     32'(err),           32'd0);
    check({tag, "_busy"},    32'(busy),          32'd0);
  endtask

  // Reset mid-frame: outputs must drop to reset values without a clock edge.
  task automatic apply_reset_mid();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_fall = cyc + 1;
  endtask

  // Plays the gamepad side of one frame and queues the expected outcome.
  task automatic run_frame(input int vi);
    frame_vec_t v;
    bit         ok;
    int         t_fall, t_tx, t_rx, t_rdy, ntx;
    logic [7:0] resp;
    sb_t        e;
    v = vecs[vi];
    t_rx = 0;
    t_rdy = 0;
    wait_cs_fall(ok, t_fall);
    if (!ok) begin
      fail_line("cs_fall_timeout");
      return;
    end
    if (exp_fall >= 0) check("poll_start", 32'(t_fall), 32'(exp_fall));
    check("busy_start", 32'(busy), 32'd1);
    for (int k = 0; k < 5; k++) begin
      wait_tx(ok, t_tx);
      if (!ok) begin
        fail_line("tx_dv_timeout");
        return;
      end
      check("tx_byte", 32'(spi.o_TX_BYTE), 32'(cmd_exp[k]));
      if (k == 0)                          check("setup_time", 32'(t_tx - t_fall), 32'(P_SETUP));
      else if (v.mode == M_STALL && k == 1) check("stall_resume", 32'(t_tx), 32'(t_rdy + 1));
      else                                 check("gap_time", 32'(t_tx - t_rx), 32'(P_GAP + 1));
      if (v.mode == M_ENDROP && k == 1) enable = 1'b0;
      if (v.mode == M_RESET && k == 3) begin
        apply_reset_mid();
        return;
      end
      if (v.mode == M_DROP && k == 2) begin
        e.is_err = 1'b1;
        e.btn    = v.exp_btn;
        e.when   = 32'(t_tx + int'(P_TMO));
        sb_q.push_back(e);
        exp_fall = t_tx + int'(P_TMO) + int'(P_POLL);
        return;
      end
      repeat (RESP_DLY) @(negedge clk);
      case (k)
        0:       resp = 8'hFF;
        1:       resp = v.id;
        2:       resp = v.ack;
        3:       resp = v.lo;
        default: resp = v.hi;
      endcase
      spi.i_RX_DATA = rev8(resp);
      spi.i_RX_DV   = 1'b1;
      t_rx = cyc;
      if (k == 4) begin
        e.is_err = v.exp_err;
        e.btn    = v.exp_btn;
        e.when   = 32'(t_rx + 1);
        sb_q.push_back(e);
        exp_fall = t_rx + 1 + int'(P_POLL);
      end
      @(negedge clk);
      spi.i_RX_DV   = 1'b0;
      spi.i_RX_DATA = 8'h00;
      if (v.mode == M_STALL && k == 0) begin
        spi.i_TX_READY = 1'b0;
        ntx = 0;
        repeat (STALL) begin
          @(negedge clk);
          if (spi.o_TX_DV) ntx++;
        end
        check("stall_no_tx", 32'(ntx), 32'd0);
        spi.i_TX_READY = 1'b1;
        t_rdy = cyc;
      end
    end
  endtask

  // Scoreboard monitor: every valid/err pulse must match a queued expectation.
  always @(negedge clk) begin
    if (bvalid || err) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_outcome actual valid=%0b err=%0b required=no-pulse (t=%0d)",
                 bvalid, err, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("outcome_err",   32'(err),        32'(mon_e.is_err));
        check("outcome_valid", 32'(bvalid),     32'(!mon_e.is_err));
        check("buttons",       32'(buttons),    32'(mon_e.btn));
        check("outcome_time",  32'(cyc),        mon_e.when);
        check("cs_release",    32'(spi.o_CS_N), 32'd1);
        check("busy_release",  32'(busy),       32'd0);
      end
    end
  end

  initial begin
    int nfall;
    cmd_exp[0] = 8'h80;
    cmd_exp[1] = 8'h42;
    cmd_exp[2] = 8'h00;
    cmd_exp[3] = 8'h00;
    cmd_exp[4] = 8'h00;
    //          id     ack    lo     hi     mode      err   buttons
    vecs[0] = '{8'h41, 8'h5A, 8'hFE, 8'hFF, M_NORM,   1'b0, 16'h0001};
    vecs[1] = '{8'h41, 8'hFF, 8'h00, 8'h00, M_NORM,   1'b1, 16'h0001};
    vecs[2] = '{8'h73, 8'h5A, 8'h00, 8'hFF, M_NORM,   1'b0, 16'h00FF};
    vecs[3] = '{8'h12, 8'h5A, 8'h00, 8'h00, M_NORM,   1'b1, 16'h00FF};
    vecs[4] = '{8'h41, 8'h5A, 8'hFF, 8'hFF, M_DROP,   1'b1, 16'h00FF};
    vecs[5] = '{8'h73, 8'h5A, 8'hFF, 8'h7F, M_STALL,  1'b0, 16'h8000};
    vecs[6] = '{8'h41, 8'h5A, 8'h55, 8'hAA, M_RESET,  1'b0, 16'h0000};
    vecs[7] = '{8'h41, 8'h5A, 8'h7F, 8'hFF, M_NORM,   1'b0, 16'h0080};
    vecs[8] = '{8'h73, 8'h5A, 8'hF0, 8'h0F, M_ENDROP, 1'b0, 16'hF00F};
    vecs[9] = '{8'h41, 8'h5A, 8'hFF, 8'hFE, M_NORM,   1'b0, 16'h0100};

    spi.i_TX_READY = 1'b1;
    spi.i_RX_DV    = 1'b0;
    spi.i_RX_DATA  = 8'h00;
    enable = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    exp_fall = cyc + 1;

    for (int i = 0; i < 9; i++) run_frame(i);

    // Enable was dropped during the last frame: no new poll may start.
    nfall = 0;
    repeat (3 * P_POLL) begin
      @(negedge clk);
      if (!spi.o_CS_N) nfall++;
    end
    check("enable_low_no_poll", 32'(nfall), 32'd0);
    enable = 1'b1;
    exp_fall = cyc + 1;
    run_frame(9);

    repeat (P_POLL / 2) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
